// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit common-anode 7-segment scan driver:
// glyph codes for the ready/set/go prompt letters and active-low segment
// patterns ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [3:0] glyph_code_t;
    typedef logic [6:0] seg_pat_t;

    // Letter codes that sit above the decimal digits
    localparam glyph_code_t GLY_R = 4'hA;
    localparam glyph_code_t GLY_G = 4'hB;
    localparam glyph_code_t GLY_Y = 4'hC;
    localparam glyph_code_t GLY_S = 4'hD;
    localparam glyph_code_t GLY_E = 4'hE;
    localparam glyph_code_t GLY_T = 4'hF;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam seg_pat_t SEG_0 = 7'b1000000;
    localparam seg_pat_t SEG_1 = 7'b1111001;
    localparam seg_pat_t SEG_2 = 7'b0100100;
    localparam seg_pat_t SEG_3 = 7'b0110000;
    localparam seg_pat_t SEG_4 = 7'b0011001;
    localparam seg_pat_t SEG_5 = 7'b0010010;
    localparam seg_pat_t SEG_6 = 7'b0000010;
    localparam seg_pat_t SEG_7 = 7'b1111000;
    localparam seg_pat_t SEG_8 = 7'b0000000;
    localparam seg_pat_t SEG_9 = 7'b0010000;
    localparam seg_pat_t SEG_R = 7'b0101111;
    localparam seg_pat_t SEG_G = 7'b1000010;
    localparam seg_pat_t SEG_Y = 7'b0010001;
    localparam seg_pat_t SEG_S = 7'b0010010;
    localparam seg_pat_t SEG_E = 7'b0000110;
    localparam seg_pat_t SEG_T = 7'b0000111;

    // Dark display values
    localparam seg_pat_t    SEG_OFF = 7'h7F;
    localparam logic [3:0]  AN_OFF  = 4'hF;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph decoder: 4-bit code to active-low 7-segment pattern.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Table lookup; every code maps to a defined glyph
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'h0:  seg = SEG_0;
            4'h1:  seg = SEG_1;
            4'h2:  seg = SEG_2;
            4'h3:  seg = SEG_3;
            4'h4:  seg = SEG_4;
            4'h5:  seg = SEG_5;
            4'h6:  seg = SEG_6;
            4'h7:  seg = SEG_7;
            4'h8:  seg = SEG_8;
            4'h9:  seg = SEG_9;
            GLY_R: seg = SEG_R;
            GLY_G: seg = SEG_G;
            GLY_Y: seg = SEG_Y;
            GLY_S: seg = SEG_S;
            GLY_E: seg = SEG_E;
            GLY_T: seg = SEG_T;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// One digit is lit per slot of SCAN_DIV cycles; the first GUARD cycles of
// each slot keep all anodes off to suppress ghosting. Codes and blank mask
// are snapshotted once per frame so a mid-frame change never tears the view.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0][3:0]  code_s;   // [3]=A .. [0]=D, same order as idx
    logic [3:0]       blank_s;

    logic       tick;
    logic       frame_end;
    logic       lit;
    logic [6:0] glyph_cur;

    assign tick      = en && (cnt == CNT_LAST);
    assign frame_end = tick && (idx == 2'd3);
    assign lit       = en && (cnt >= CNT_GUARD) && !blank_s[idx];
    assign dp        = 1'b1;

    seg7_glyph u_glyph (
        .code (code_s[idx]),
        .seg  (glyph_cur)
    );

    // Prescaler and slot index; both freeze while en is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Frame snapshot of codes and blank mask; starts fully blanked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_s     <= '0;
            blank_s    <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                code_s  <= {A, B, C, D};
                blank_s <= blank;
            end
        end
    end

    // Registered pin drive: one cycle behind the (cnt, idx) that selects it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (lit) begin
            an  <= ~(4'b0001 << idx);
            seg <= glyph_cur;
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with SCAN_DIV=4, GUARD=1. The reference tracks
// the number of enabled cycles since reset and derives slot/position from it.
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int GD = 1;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] A = 4'h0, B = 4'h0, C = 4'h0, D = 4'h0;
    logic [3:0] blank = 4'h0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    // reference state
    int         n_en;
    logic [3:0] r_code [4];
    logic [3:0] r_blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ft;

    seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_ref(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0101111;
            4'hB: return 7'b1000010;
            4'hC: return 7'b0010001;
            4'hD: return 7'b0010010;
            4'hE: return 7'b0000110;
            default: return 7'b0000111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_en    = 0;
        r_blank = 4'b1111;
        for (int k = 0; k < 4; k++) r_code[k] = 4'h0;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_ft  = 1'b0;
    endtask

    // Advance one clock, update the reference from the inputs seen at that edge, compare
    task automatic step(input string tag);
        int pos, slot, c;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            pos  = n_en % FR;
            slot = pos / SD;
            c    = pos % SD;
            if (en && c >= GD && !r_blank[slot]) begin
                e_an  = ~(4'b0001 << slot);
                e_seg = glyph_ref(r_code[slot]);
            end else begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
            end
            e_ft = en && (pos == FR - 1);
            if (e_ft) begin
                r_code[3] = A;
                r_code[2] = B;
                r_code[1] = C;
                r_code[0] = D;
                r_blank   = blank;
            end
            if (en) n_en++;
        end
        #1;
        check({tag, ".an"},  {3'b000, an},         {3'b000, e_an});
        check({tag, ".seg"}, seg,                   e_seg);
        check({tag, ".ft"},  {6'b0, frame_tick},    {6'b0, e_ft});
        check({tag, ".dp"},  {6'b0, dp},            7'h01);
    endtask

    initial begin
        int ft_seen;
        model_reset();

        // 1: reset held 10 cycles with en=1, then a dark first frame
        #1 reset = 1'b0;
        en = 1'b1;
        A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4; blank = 4'b0000;
        repeat (10) step("rst_hold");
        reset = 1'b1;
        ft_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            step("frame1");
            if (frame_tick) ft_seen = i;
        end
        check("first_ft_cycle", 7'(ft_seen), 7'd16);

        // 2: 1,2,3,4 shown right-to-left as 4,3,2,1
        repeat (32) step("digits");

        // 3: leftmost blanked, r/E/y on the others
        blank = 4'b1000; A = 4'h0; B = 4'hA; C = 4'hE; D = 4'hC;
        repeat (32) step("letters");

        // 4: D changes mid-frame; display holds until next snapshot
        blank = 4'b0000; D = 4'h1;
        repeat (20) step("tear_pre");
        D = 4'h8;
        repeat (36) step("tear_post");

        // 5: en dropped for 7 cycles mid-slot
        repeat (6) step("en_pre");
        en = 1'b0;
        repeat (7) step("en_off");
        en = 1'b1;
        repeat (24) step("en_resume");

        // 6: asynchronous reset between edges
        repeat (5) step("arst_pre");
        #2 reset = 1'b0;
        #1;
        check("arst_an",  {3'b000, an},      7'h0F);
        check("arst_seg", seg,                7'h7F);
        check("arst_ft",  {6'b0, frame_tick}, 7'h00);
        model_reset();
        repeat (3) step("arst_hold");
        reset = 1'b1;
        repeat (40) step("arst_after");

        // Randomized inputs and enable gaps
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) begin
                A     = 4'($urandom);
                B     = 4'($urandom);
                C     = 4'($urandom);
                D     = 4'($urandom);
                blank = 4'($urandom_range(0, 15));
            end
            en = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
